// File: rtl/feature_read_requester.sv
// feature_read_requester: walks an element-addressed feature volume as a
// series of word-aligned bus reads, one outstanding at a time, and reports
// which slice of each returned beat belongs to the volume.
module feature_read_requester #(
    parameter int MAX_READ_WIDTH = 16,
    parameter int MEM_ADDR_W     = 32,
    parameter int SEQ_W          = 4,
    parameter int VOL_W          = 16,
    localparam int POS_W         = $clog2(MAX_READ_WIDTH),
    localparam int WW_W          = POS_W + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [MEM_ADDR_W-1:0] base_addr,
    input  logic [VOL_W-1:0]      volume_size,
    input  logic                  hold,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [MEM_ADDR_W-1:0] req_addr,
    output logic [SEQ_W-1:0]      req_seq,
    input  logic                  resp_valid,
    input  logic [SEQ_W-1:0]      resp_seq,
    output logic [SEQ_W-1:0]      exp_seq,
    output logic [POS_W-1:0]      read_pos,
    output logic [WW_W-1:0]       write_width,
    output logic                  beat_accept,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t                state_reg;
    logic                  req_valid_reg;
    logic [MEM_ADDR_W-1:0] cur_addr_reg;
    logic [VOL_W-1:0]      remaining_reg;
    logic [SEQ_W-1:0]      exp_seq_reg;
    logic [POS_W-1:0]      read_pos_reg;
    logic [WW_W-1:0]       write_width_reg;

    logic                  beat_hit;
    logic [POS_W-1:0]      off_next;
    logic [WW_W-1:0]       space_next;
    logic [WW_W-1:0]       write_width_next;

    // Beat matching and slice sizing; abort wins over an accept in the same cycle.
    always_comb begin
        beat_hit   = (state_reg == S_WAIT) && resp_valid && (resp_seq == exp_seq_reg) && !abort;
        off_next   = cur_addr_reg[POS_W-1:0];
        space_next = WW_W'(MAX_READ_WIDTH) - {1'b0, off_next};
        if (remaining_reg < VOL_W'(space_next)) begin
            write_width_next = WW_W'(remaining_reg);
        end else begin
            write_width_next = space_next;
        end
    end

    // Request/response sequencer; reset, then abort, take precedence over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            req_valid_reg   <= 1'b0;
            cur_addr_reg    <= '0;
            remaining_reg   <= '0;
            exp_seq_reg     <= '0;
            read_pos_reg    <= '0;
            write_width_reg <= '0;
        end else if (abort) begin
            // Bumping the tag makes any late response to the dropped request miss.
            state_reg     <= S_IDLE;
            req_valid_reg <= 1'b0;
            exp_seq_reg   <= exp_seq_reg + 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        cur_addr_reg  <= base_addr;
                        remaining_reg <= volume_size;
                        if (volume_size == '0) begin
                            state_reg <= S_FIN;
                        end else begin
                            state_reg     <= S_REQ;
                            req_valid_reg <= !hold;
                        end
                    end
                end
                S_REQ: begin
                    if (req_valid_reg && req_ready) begin
                        state_reg     <= S_WAIT;
                        req_valid_reg <= 1'b0;
                    end else begin
                        // Holding mid-handshake withdraws the request; it is reissued unchanged later.
                        req_valid_reg <= !hold;
                    end
                end
                S_WAIT: begin
                    if (beat_hit) begin
                        cur_addr_reg    <= cur_addr_reg + MEM_ADDR_W'(write_width_next);
                        remaining_reg   <= remaining_reg - VOL_W'(write_width_next);
                        exp_seq_reg     <= exp_seq_reg + 1'b1;
                        read_pos_reg    <= off_next;
                        write_width_reg <= write_width_next;
                        if (remaining_reg == VOL_W'(write_width_next)) begin
                            state_reg <= S_FIN;
                        end else begin
                            state_reg     <= S_REQ;
                            req_valid_reg <= !hold;
                        end
                    end
                end
                S_FIN: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg     <= S_IDLE;
                    req_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Output view: accepted-beat slice is live during accept, otherwise the last one is held.
    always_comb begin
        req_valid   = req_valid_reg;
        req_addr    = {cur_addr_reg[MEM_ADDR_W-1:POS_W], {POS_W{1'b0}}};
        req_seq     = exp_seq_reg;
        exp_seq     = exp_seq_reg;
        beat_accept = beat_hit;
        read_pos    = beat_hit ? off_next : read_pos_reg;
        write_width = beat_hit ? write_width_next : write_width_reg;
        busy        = (state_reg == S_REQ) || (state_reg == S_WAIT);
        done        = (state_reg == S_FIN) && !abort;
    end

endmodule

// File: tb/tb_feature_read_requester.sv
// Directed bench for feature_read_requester with default parameters.
module tb_feature_read_requester;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] base_addr;
    logic [15:0] volume_size;
    logic        hold;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_seq;
    logic        resp_valid;
    logic [3:0]  resp_seq;
    logic [3:0]  exp_seq;
    logic [3:0]  read_pos;
    logic [4:0]  write_width;
    logic        beat_accept;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    feature_read_requester dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .base_addr   (base_addr),
        .volume_size (volume_size),
        .hold        (hold),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_seq     (req_seq),
        .resp_valid  (resp_valid),
        .resp_seq    (resp_seq),
        .exp_seq     (exp_seq),
        .read_pos    (read_pos),
        .write_width (write_width),
        .beat_accept (beat_accept),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input logic [31:0] base, input logic [15:0] vol);
        base_addr   = base;
        volume_size = vol;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    // Expects a live request in REQ, completes the handshake, expects WAIT.
    task automatic expect_req(input string tag, input logic [31:0] addr, input logic [3:0] seq);
        check({tag, "_valid"}, req_valid, 1);
        check({tag, "_addr"}, req_addr, addr);
        check({tag, "_seq"}, req_seq, seq);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check({tag, "_wait_valid"}, req_valid, 0);
        check({tag, "_wait_busy"}, busy, 1);
    endtask

    // Presents a matching beat and checks the combinational slice report.
    task automatic give_beat(input string tag, input logic [3:0] seq, input logic [3:0] pos, input logic [4:0] ww);
        resp_valid = 1'b1;
        resp_seq   = seq;
        #1;
        check({tag, "_accept"}, beat_accept, 1);
        check({tag, "_pos"}, read_pos, pos);
        check({tag, "_width"}, write_width, ww);
        tick();
        resp_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; volume_size = '0;
        hold = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_seq = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_valid", req_valid, 0);
        check("rst_addr", req_addr, 0);
        check("rst_seq", req_seq, 0);
        check("rst_exp", exp_seq, 0);
        check("rst_pos", read_pos, 0);
        check("rst_width", write_width, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // Aligned volume: 40 elements at 0x100.
        launch(32'h100, 16'd40);
        check("al_busy", busy, 1);
        expect_req("al_r0", 32'h100, 4'd0);
        give_beat("al_b0", 4'd0, 4'd0, 5'd16);
        check("al_hold_pos", read_pos, 0);
        check("al_hold_width", write_width, 16);
        expect_req("al_r1", 32'h110, 4'd1);
        give_beat("al_b1", 4'd1, 4'd0, 5'd16);
        expect_req("al_r2", 32'h120, 4'd2);
        give_beat("al_b2", 4'd2, 4'd0, 5'd8);
        check("al_done", done, 1);
        check("al_fin_busy", busy, 0);
        tick();
        check("al_done_once", done, 0);
        check("al_idle_busy", busy, 0);
        check("al_kept_width", write_width, 8);

        // Unaligned volume: 5 elements at 0x10D, with a stale tag in between.
        launch(32'h10D, 16'd5);
        expect_req("un_r0", 32'h100, 4'd3);
        resp_valid = 1'b1; resp_seq = 4'd2;
        #1;
        check("stale_accept", beat_accept, 0);
        check("stale_width", write_width, 8);
        tick();
        resp_valid = 1'b0;
        check("stale_busy", busy, 1);
        check("stale_exp", exp_seq, 3);
        give_beat("un_b0", 4'd3, 4'd13, 5'd3);
        expect_req("un_r1", 32'h110, 4'd4);
        give_beat("un_b1", 4'd4, 4'd0, 5'd2);
        check("un_done", done, 1);
        tick();

        // Walk the tag up to 15 with idle aborts, then wrap it with one read.
        for (int i = 0; i < 10; i++) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        check("wrap_pre", exp_seq, 15);
        check("wrap_no_done", done, 0);
        launch(32'h3FF, 16'd1);
        expect_req("wr_r0", 32'h3F0, 4'd15);
        give_beat("wr_b0", 4'd15, 4'd15, 5'd1);
        check("wrap_exp", exp_seq, 0);
        check("wrap_done", done, 1);
        tick();

        // Hold at entry, then backpressure, then hold rising mid-handshake.
        hold = 1'b1;
        launch(32'h200, 16'd16);
        check("hold_busy", busy, 1);
        check("hold_v0", req_valid, 0);
        tick();
        check("hold_v1", req_valid, 0);
        hold = 1'b0;
        tick();
        check("unhold_valid", req_valid, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_valid", req_valid, 1);
            check("bp_addr", req_addr, 32'h200);
            check("bp_seq", req_seq, 0);
        end
        hold = 1'b1;
        tick();
        check("hold_rise_valid", req_valid, 0);
        hold = 1'b0;
        tick();
        expect_req("hd_r0", 32'h200, 4'd0);
        give_beat("hd_b0", 4'd0, 4'd0, 5'd16);
        check("hd_done", done, 1);
        tick();

        // Zero-size start completes without a request.
        launch(32'h55, 16'd0);
        check("zero_done", done, 1);
        check("zero_valid", req_valid, 0);
        check("zero_busy", busy, 0);
        tick();
        check("zero_done_off", done, 0);

        // Abort while waiting; the late response must be ignored.
        launch(32'h300, 16'd32);
        expect_req("ab_r0", 32'h300, 4'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        check("ab_exp", exp_seq, 2);
        resp_valid = 1'b1; resp_seq = 4'd1;
        #1;
        check("ab_late_accept", beat_accept, 0);
        tick();
        resp_valid = 1'b0;
        check("ab_late_done", done, 0);
        check("ab_late_busy", busy, 0);

        // Reset in the middle of a read overrides start/abort and clears everything.
        launch(32'h400, 16'd20);
        expect_req("rs_r0", 32'h400, 4'd2);
        give_beat("rs_b0", 4'd2, 4'd0, 5'd16);
        check("rs_mid_valid", req_valid, 1);
        reset = 1'b1; start = 1'b1; abort = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        resp_valid = 1'b1; resp_seq = 4'd0;
        #1;
        check("rs_valid", req_valid, 0);
        check("rs_addr", req_addr, 0);
        check("rs_seq", req_seq, 0);
        check("rs_exp", exp_seq, 0);
        check("rs_pos", read_pos, 0);
        check("rs_width", write_width, 0);
        check("rs_accept", beat_accept, 0);
        check("rs_busy", busy, 0);
        check("rs_done", done, 0);
        tick();
        resp_valid = 1'b0;
        check("rs_after_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
